// File: rtl/frame_burst_sched.sv
// rtl/frame_burst_sched.sv - round-robin write/read burst scheduler for a frame buffer
module frame_burst_sched #(
  parameter int BURST_LEN   = 16,
  parameter int AW          = 28,
  parameter int FRAME_WORDS = 2073600
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wfifo_val_i,
  input  logic [23:0]   wfifo_data_i,
  output logic          wfifo_incr_o,
  input  logic          rfifo_rdy_i,
  output logic [23:0]   rfifo_data_o,
  output logic          rfifo_incr_o,
  input  logic          wr_sof_i,
  input  logic          rd_sof_i,
  output logic          cmd_val_o,
  input  logic          cmd_rdy_i,
  output logic          cmd_we_o,
  output logic [AW-1:0] cmd_addr_o,
  output logic [23:0]   mem_wdata_o,
  input  logic          mem_wrdy_i,
  input  logic [23:0]   mem_rdata_i,
  input  logic          mem_rval_i,
  output logic          err_o
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [AW-1:0] BURST_STEP = AW'(BURST_LEN);
  localparam logic [AW-1:0] LAST_BURST = AW'(FRAME_WORDS - BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic [CW-1:0] beat_q;
  logic          rd_next_q, wr_sof_q, rd_sof_q, err_q;
  logic          grant_wr, grant_rd, beat, last_beat;

  function automatic logic [AW-1:0] advance(input logic [AW-1:0] a);
    return (a == LAST_BURST) ? '0 : a + BURST_STEP;
  endfunction

  // Outputs are gated by rst_ni so nothing is issued or moved while reset is held.
  always_comb begin
    state_d      = state_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    beat         = 1'b0;
    cmd_val_o    = 1'b0;
    cmd_we_o     = 1'b0;
    cmd_addr_o   = wr_addr_q;
    wfifo_incr_o = 1'b0;
    rfifo_incr_o = 1'b0;
    mem_wdata_o  = wfifo_data_i;
    rfifo_data_o = mem_rdata_i;
    case (state_q)
      IDLE: begin
        if (wfifo_val_i && rfifo_rdy_i) begin
          grant_rd = rd_next_q;
          grant_wr = !rd_next_q;
        end else begin
          grant_wr = wfifo_val_i;
          grant_rd = rfifo_rdy_i;
        end
        if (grant_wr)      state_d = WR_CMD;
        else if (grant_rd) state_d = RD_CMD;
      end
      WR_CMD: begin
        cmd_val_o  = rst_ni;
        cmd_we_o   = 1'b1;
        cmd_addr_o = wr_addr_q;
        if (cmd_rdy_i) state_d = WR_DATA;
      end
      WR_DATA: begin
        wfifo_incr_o = rst_ni & mem_wrdy_i;
        beat         = mem_wrdy_i;
        if (beat && beat_q == LAST_BEAT) state_d = IDLE;
      end
      RD_CMD: begin
        cmd_val_o  = rst_ni;
        cmd_we_o   = 1'b0;
        cmd_addr_o = rd_addr_q;
        if (cmd_rdy_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        rfifo_incr_o = rst_ni & mem_rval_i;
        beat         = mem_rval_i;
        if (beat && beat_q == LAST_BEAT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    last_beat = beat && (beat_q == LAST_BEAT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      beat_q    <= '0;
      rd_next_q <= 1'b1;
      wr_sof_q  <= 1'b0;
      rd_sof_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (grant_rd)      rd_next_q <= 1'b0;
      else if (grant_wr) rd_next_q <= 1'b1;

      if ((state_q == WR_CMD || state_q == RD_CMD) && cmd_rdy_i) beat_q <= '0;
      else if (beat)                                             beat_q <= beat_q + CW'(1);

      if (mem_rval_i && state_q != RD_DATA) err_q <= 1'b1;

      // A pending frame start restarts the region; at burst end it beats the advance.
      if (state_q == IDLE && (wr_sof_q || wr_sof_i)) begin
        wr_addr_q <= '0;
        wr_sof_q  <= 1'b0;
      end else begin
        if (wr_sof_i) wr_sof_q <= 1'b1;
        if (state_q == WR_DATA && last_beat)
          wr_addr_q <= (wr_sof_q || wr_sof_i) ? '0 : advance(wr_addr_q);
      end

      if (state_q == IDLE && (rd_sof_q || rd_sof_i)) begin
        rd_addr_q <= '0;
        rd_sof_q  <= 1'b0;
      end else begin
        if (rd_sof_i) rd_sof_q <= 1'b1;
        if (state_q == RD_DATA && last_beat)
          rd_addr_q <= (rd_sof_q || rd_sof_i) ? '0 : advance(rd_addr_q);
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_frame_burst_sched.sv
// tb/tb_frame_burst_sched.sv - directed scoreboard bench for frame_burst_sched
module tb_frame_burst_sched;

  localparam int BL = 16;
  localparam int AW = 28;
  localparam int FW = 64;
  localparam int CMD = 0, WR = 1, RD = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          wfifo_val_i;
  logic [23:0]   wfifo_data_i;
  logic          wfifo_incr_o;
  logic          rfifo_rdy_i;
  logic [23:0]   rfifo_data_o;
  logic          rfifo_incr_o;
  logic          wr_sof_i;
  logic          rd_sof_i;
  logic          cmd_val_o;
  logic          cmd_rdy_i;
  logic          cmd_we_o;
  logic [AW-1:0] cmd_addr_o;
  logic [23:0]   mem_wdata_o;
  logic          mem_wrdy_i;
  logic [23:0]   mem_rdata_i;
  logic          mem_rval_i;
  logic          err_o;

  int   tests = 0, fails = 0;
  int   ncmd = 0, nwr = 0, nrd = 0;
  int   rd_left = 0;
  logic rd_start = 1'b0;
  logic rval_force = 1'b0;
  logic [AW:0] exp_q[$];

  always #5 clk = ~clk;

  frame_burst_sched #(.BURST_LEN(BL), .AW(AW), .FRAME_WORDS(FW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wfifo_val_i(wfifo_val_i), .wfifo_data_i(wfifo_data_i), .wfifo_incr_o(wfifo_incr_o),
    .rfifo_rdy_i(rfifo_rdy_i), .rfifo_data_o(rfifo_data_o), .rfifo_incr_o(rfifo_incr_o),
    .wr_sof_i(wr_sof_i), .rd_sof_i(rd_sof_i),
    .cmd_val_o(cmd_val_o), .cmd_rdy_i(cmd_rdy_i), .cmd_we_o(cmd_we_o), .cmd_addr_o(cmd_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wrdy_i(mem_wrdy_i),
    .mem_rdata_i(mem_rdata_i), .mem_rval_i(mem_rval_i),
    .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt(input int which);
    case (which)
      CMD:     return ncmd;
      WR:      return nwr;
      default: return nrd;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int target, input string tag);
    int budget = 400;
    while (cnt(which) < target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (cnt(which) < target) begin
      tests++;
      fails++;
      $error("FAIL %s: timeout, observed %0d expected %0d", tag, cnt(which), target);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick(2);
    rst_ni = 1'b1;
  endtask

  // Memory read model: after a read command handshake, return BL consecutive beats.
  always @(posedge clk) begin
    #1;
    if (rd_left > 0) rd_left--;
    if (rd_start) begin
      rd_left  = BL;
      rd_start = 1'b0;
    end
    wfifo_data_i = 24'($urandom);
    mem_rdata_i  = 24'($urandom);
  end
  assign mem_rval_i = (rd_left > 0) || rval_force;

  // Scoreboard: commands popped on handshake, data beats checked against the sources.
  always @(negedge clk) begin
    logic [AW:0] e;
    if (rst_ni) begin
      if (cmd_val_o && cmd_rdy_i) begin
        ncmd++;
        if (!cmd_we_o) rd_start = 1'b1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL cmd_unexpected: observed we=%0b addr=%0d expected none", cmd_we_o, cmd_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("cmd_we_addr", 64'({cmd_we_o, cmd_addr_o}), 64'(e));
        end
      end
      if (wfifo_incr_o) begin
        nwr++;
        check("wdata", 64'(mem_wdata_o), 64'(wfifo_data_i));
      end
      if (rfifo_incr_o) begin
        nrd++;
        check("rdata", 64'(rfifo_data_o), 64'(mem_rdata_i));
      end
    end
  end

  initial begin
    int base, w0, r0, budget;
    rst_ni = 1'b0; wfifo_val_i = 1'b1; rfifo_rdy_i = 1'b1; cmd_rdy_i = 1'b1;
    mem_wrdy_i = 1'b1; wr_sof_i = 1'b0; rd_sof_i = 1'b0;
    wfifo_data_i = '0; mem_rdata_i = '0;
    tick(2);
    @(negedge clk);
    check("rst_cmd_val", 64'(cmd_val_o), 64'(0));
    check("rst_wincr", 64'(wfifo_incr_o), 64'(0));
    check("rst_rincr", 64'(rfifo_incr_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    @(posedge clk); #1;
    wfifo_val_i = 1'b0; rfifo_rdy_i = 1'b0; rst_ni = 1'b1;
    tick(2);
    check("idle_cmd_val", 64'(cmd_val_o), 64'(0));

    // Write-only traffic: two back-to-back bursts
    exp_q.push_back({1'b1, 28'd0});
    exp_q.push_back({1'b1, 28'd16});
    base = ncmd;
    wfifo_val_i = 1'b1;
    wait_cnt(CMD, base + 1, "wr_cmd0");
    w0 = nwr;
    wait_cnt(CMD, base + 2, "wr_cmd1");
    check("wr_burst_beats", 64'(nwr - w0), 64'(16));
    tick(1);
    wfifo_val_i = 1'b0;
    wait_cnt(WR, w0 + 32, "wr_burst1_done");
    tick(3);
    check("wr_only_idle", 64'(cmd_val_o), 64'(0));

    // Both eligible: read wins first tie, then strict alternation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 28'(16 * i)});
      exp_q.push_back({1'b1, 28'(16 * i)});
    end
    base = ncmd; w0 = nwr; r0 = nrd;
    wfifo_val_i = 1'b1; rfifo_rdy_i = 1'b1;
    wait_cnt(CMD, base + 6, "rr_cmds");
    tick(1);
    wfifo_val_i = 1'b0; rfifo_rdy_i = 1'b0;
    wait_cnt(WR, w0 + 48, "rr_wr_done");
    wait_cnt(RD, r0 + 48, "rr_rd_done");
    tick(2);
    check("rr_wr_beats", 64'(nwr - w0), 64'(48));
    check("rr_rd_beats", 64'(nrd - r0), 64'(48));
    check("rr_sb_empty", 64'(exp_q.size()), 64'(0));

    // Command stall: held stable, no pushes; burst at 48 then wraps to 0
    cmd_rdy_i = 1'b0; rfifo_rdy_i = 1'b1;
    budget = 50;
    while (!cmd_val_o && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    r0 = nrd;
    for (int i = 0; i < 5; i++) begin
      check("stall_val", 64'(cmd_val_o), 64'(1));
      check("stall_we", 64'(cmd_we_o), 64'(0));
      check("stall_addr", 64'(cmd_addr_o), 64'(48));
      check("stall_rincr", 64'(rfifo_incr_o), 64'(0));
      @(negedge clk); #1;
    end
    exp_q.push_back({1'b0, 28'd48});
    @(posedge clk); #1;
    rfifo_rdy_i = 1'b0; cmd_rdy_i = 1'b1;
    wait_cnt(RD, r0 + 16, "stall_burst_done");
    tick(3);

    // Small frame: write wrap after four bursts
    do_reset();
    exp_q.push_back({1'b1, 28'd0});
    exp_q.push_back({1'b1, 28'd16});
    exp_q.push_back({1'b1, 28'd32});
    exp_q.push_back({1'b1, 28'd48});
    exp_q.push_back({1'b1, 28'd0});
    base = ncmd; w0 = nwr;
    wfifo_val_i = 1'b1;
    wait_cnt(CMD, base + 5, "wrap_cmds");
    tick(1);
    wfifo_val_i = 1'b0;
    wait_cnt(WR, w0 + 80, "wrap_done");
    tick(2);

    // Read frame start mid-burst at 32: burst completes, next read restarts at 0
    exp_q.push_back({1'b0, 28'd0});
    exp_q.push_back({1'b0, 28'd16});
    exp_q.push_back({1'b0, 28'd32});
    base = ncmd;
    rfifo_rdy_i = 1'b1;
    wait_cnt(CMD, base + 3, "sof_rd_cmds");
    r0 = nrd;
    tick(1);
    rfifo_rdy_i = 1'b0;
    wait_cnt(RD, r0 + 5, "sof_mid");
    tick(1);
    rd_sof_i = 1'b1;
    tick(1);
    rd_sof_i = 1'b0;
    wait_cnt(RD, r0 + 16, "sof_burst_done");
    tick(3);
    check("sof_no_truncate", 64'(nrd - r0), 64'(16));
    exp_q.push_back({1'b0, 28'd0});
    base = ncmd;
    rfifo_rdy_i = 1'b1;
    wait_cnt(CMD, base + 1, "sof_next_cmd");
    r0 = nrd;
    tick(1);
    rfifo_rdy_i = 1'b0;
    wait_cnt(RD, r0 + 16, "sof_next_done");
    tick(2);

    // Stray read beat in IDLE: sticky error, no push
    check("err_clear", 64'(err_o), 64'(0));
    rval_force = 1'b1;
    @(negedge clk);
    check("stray_rincr", 64'(rfifo_incr_o), 64'(0));
    @(posedge clk); #1;
    rval_force = 1'b0;
    @(negedge clk);
    check("err_set", 64'(err_o), 64'(1));
    tick(3);
    check("err_sticky", 64'(err_o), 64'(1));

    // Reset after 7 beats of a write burst at 16
    exp_q.push_back({1'b1, 28'd16});
    base = ncmd;
    wfifo_val_i = 1'b1;
    wait_cnt(CMD, base + 1, "rst_wr_cmd");
    w0 = nwr;
    tick(1);
    wfifo_val_i = 1'b0;
    wait_cnt(WR, w0 + 7, "rst_wr_7beats");
    tick(1);
    rst_ni = 1'b0;
    @(negedge clk);
    check("rst_mid_wincr", 64'(wfifo_incr_o), 64'(0));
    check("rst_mid_cmdval", 64'(cmd_val_o), 64'(0));
    tick(1);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_err_cleared", 64'(err_o), 64'(0));
    tick(4);
    check("rst_beats_kept", 64'(nwr - w0), 64'(7));
    check("rst_idle", 64'(cmd_val_o), 64'(0));
    exp_q.push_back({1'b1, 28'd0});
    base = ncmd;
    wfifo_val_i = 1'b1;
    wait_cnt(CMD, base + 1, "rst_next_cmd");
    w0 = nwr;
    tick(1);
    wfifo_val_i = 1'b0;
    wait_cnt(WR, w0 + 16, "rst_next_done");
    tick(2);

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
